cache_refill_unit: RTL
======================

Name: cache_refill_unit

Overview:
Miss-refill engine between the cache control unit and main memory. On a miss it latches the missing word address and fetches the whole block from main memory, one word per memory acknowledge. It assembles the words into a line buffer, then issues a one-cycle line write into the cache data/tag arrays. The control unit's rRead drives miss_req; line_wr and the line_* outputs feed the cache array write port.

Parameters:
ADDR_W, 15, word-address width of miss_addr and mem_addr
WORD_W, 32, data word width
OFFSET_W, 2, block-offset bits; WORDS = 2**OFFSET_W words per block

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
miss_req  input  1  refill request (level), sampled only in IDLE
miss_addr  input  ADDR_W  word address of the missing word
busy  output  1  high in every state except IDLE
mem_rd  output  1  memory read request, level, held until acknowledged
mem_addr  output  ADDR_W  word address of the current memory read
mem_rdata  input  WORD_W  memory read data, valid when mem_valid=1
mem_valid  input  1  memory acknowledge; ignored unless mem_rd=1
line_wr  output  1  one-cycle cache line write strobe
line_addr  output  ADDR_W-OFFSET_W  block address (miss_addr >> OFFSET_W)
line_data  output  WORD_W*WORDS  assembled block; word i at bits [i*WORD_W +: WORD_W]
refill_done  output  1  one-cycle pulse, coincident with line_wr

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE. busy, mem_rd, line_wr and refill_done are 0. mem_addr, line_addr, line_data and the word counter are 0.
- States: IDLE, REQ, WRITE, COOL.
- IDLE, miss_req=1 at an edge:
  - latch base = miss_addr with low OFFSET_W bits cleared; cnt=0.
  - next state REQ; mem_rd=1; mem_addr=base; busy=1.
  - miss_req=0: stay in IDLE, outputs hold.
- REQ, at each edge with mem_valid=1:
  - line_data word[cnt] <= mem_rdata.
  - If cnt != WORDS-1: cnt++; mem_addr=base+cnt+1; mem_rd stays 1.
  - If cnt == WORDS-1: mem_rd=0; next state WRITE; line_wr=1; refill_done=1; line_addr=base>>OFFSET_W.
- REQ, mem_valid=0: hold all outputs (wait states are unbounded).
- WRITE: lasts exactly one cycle. Next state COOL; line_wr=0; refill_done=0. line_data and line_addr hold their values until the next refill overwrites them.
- COOL: one cycle, miss_req ignored, busy=1, so the tag compare sees the new line before a re-request. Next state IDLE; busy=0.
- miss_req in REQ, WRITE or COOL is ignored; a new miss_addr never disturbs an in-flight refill.
- mem_valid while mem_rd=0 is ignored; line_data is unchanged.
- Fill order is always word 0 to WORDS-1, ascending from base regardless of miss offset (no critical-word-first). Address arithmetic stays within the block; no wrap beyond base+WORDS-1.
- Zero-wait-state latency: miss_req sampled at edge k, words captured at edges k+1..k+WORDS, line_wr high after edge k+WORDS for one cycle, busy low after edge k+WORDS+2.
- Reset mid-refill aborts immediately: line_wr is not issued and partial line_data is cleared to 0.

Test Plan:
- Reset then idle: rst pulse, miss_req=0 for 5 cycles. Required: busy=0, mem_rd=0, line_wr=0, line_data=0 throughout.
- Zero-wait refill: miss_addr=0x0126, mem_valid=1 constant, mem_rdata=0xA0000000+mem_addr. Required: mem_addr sequence 0x0124, 0x0125, 0x0126, 0x0127 on consecutive cycles. Then line_wr=refill_done=1 for exactly one cycle with line_addr=0x0049 and line_data words = 0xA0000124..0xA0000127. busy falls 2 cycles after line_wr.
- Wait states: same request with mem_valid high only every 3rd cycle. Required: mem_rd stays 1 and mem_addr stable between acks; same final line_data; line_wr appears after the 4th ack.
- Request during refill: assert miss_req with miss_addr=0x7FF0 mid-REQ and during COOL. Required: ignored; the first refill completes with line_addr=0x0049. A new refill starts only if miss_req is high in IDLE afterwards.
- Reset mid-refill: assert rst after the 2nd word is captured. Required: immediately busy=0, mem_rd=0, line_data=0; no line_wr pulse. The next miss_req=1 with miss_addr=0x0008 fetches 0x0008..0x000B.
- Spurious ack: mem_valid=1 with mem_rdata=0xDEADBEEF while idle. Required: line_data unchanged, no state change.

Source files
------------

// File: rtl/cache_refill_unit_if.sv
// Refill-engine bus: miss request from the cache control unit, word reads to
// main memory, and the line write port into the cache data/tag arrays.
interface cache_refill_unit_if #(
    parameter int ADDR_W   = 15,
    parameter int WORD_W   = 32,
    parameter int OFFSET_W = 2
);
    localparam int WORDS = 2 ** OFFSET_W;

    logic                         miss_req;
    logic [ADDR_W-1:0]            miss_addr;
    logic                         busy;
    logic                         mem_rd;
    logic [ADDR_W-1:0]            mem_addr;
    logic [WORD_W-1:0]            mem_rdata;
    logic                         mem_valid;
    logic                         line_wr;
    logic [ADDR_W-OFFSET_W-1:0]   line_addr;
    logic [WORD_W*WORDS-1:0]      line_data;
    logic                         refill_done;

    // master: the refill engine; slave: control unit, memory and cache arrays.
    modport master (
        input  miss_req, miss_addr, mem_rdata, mem_valid,
        output busy, mem_rd, mem_addr, line_wr, line_addr, line_data, refill_done
    );

    modport slave (
        output miss_req, miss_addr, mem_rdata, mem_valid,
        input  busy, mem_rd, mem_addr, line_wr, line_addr, line_data, refill_done
    );
endinterface

// File: rtl/cache_refill_unit.sv
// Miss-refill engine: fetches a whole block word by word from main memory,
// assembles it in a line buffer and writes it to the cache in one strobe.
module cache_refill_unit #(
    parameter int ADDR_W   = 15,
    parameter int WORD_W   = 32,
    parameter int OFFSET_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_refill_unit_if.master  bus
);
    localparam int WORDS  = 2 ** OFFSET_W;
    localparam int BLK_W  = ADDR_W - OFFSET_W;
    localparam int LINE_W = WORD_W * WORDS;
    localparam logic [OFFSET_W-1:0] CNT_LAST = OFFSET_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, COOL} state_t;

    state_t              r_state, w_state_nxt;
    logic [BLK_W-1:0]    r_blk, w_blk;
    logic [OFFSET_W-1:0] r_cnt, w_cnt;
    logic [OFFSET_W-1:0] w_cnt_inc;
    logic                r_busy, w_busy;
    logic                r_mem_rd, w_mem_rd;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
    logic                r_line_wr, w_line_wr;
    logic [BLK_W-1:0]    r_line_addr, w_line_addr;
    logic [LINE_W-1:0]   r_line_data, w_line_data;
    logic                w_last_ack;

    assign w_cnt_inc  = r_cnt + OFFSET_W'(1);
    assign w_last_ack = bus.mem_valid && (r_cnt == CNT_LAST);

    // State and every output are registered together; reset also clears the
    // line buffer so an aborted refill leaves no partial line visible.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_line_wr   <= 1'b0;
            r_line_addr <= '0;
            r_line_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_blk       <= w_blk;
            r_cnt       <= w_cnt;
            r_busy      <= w_busy;
            r_mem_rd    <= w_mem_rd;
            r_mem_addr  <= w_mem_addr;
            r_line_wr   <= w_line_wr;
            r_line_addr <= w_line_addr;
            r_line_data <= w_line_data;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.miss_req) w_state_nxt = REQ;
            REQ:     if (w_last_ack)   w_state_nxt = WRITE;
            WRITE:   w_state_nxt = COOL;
            COOL:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_blk       = r_blk;
        w_cnt       = r_cnt;
        w_mem_rd    = r_mem_rd;
        w_mem_addr  = r_mem_addr;
        w_line_wr   = 1'b0;
        w_line_addr = r_line_addr;
        w_line_data = r_line_data;
        w_busy      = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (bus.miss_req) begin
                    w_blk      = bus.miss_addr[ADDR_W-1:OFFSET_W];
                    w_cnt      = '0;
                    w_mem_rd   = 1'b1;
                    w_mem_addr = {bus.miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                end
            end
            REQ: begin
                if (bus.mem_valid) begin
                    w_line_data[int'(r_cnt)*WORD_W +: WORD_W] = bus.mem_rdata;
                    if (r_cnt == CNT_LAST) begin
                        w_mem_rd    = 1'b0;
                        w_line_wr   = 1'b1;
                        w_line_addr = r_blk;
                    end else begin
                        // Offset bits advance alone, so the fetch never leaves the block.
                        w_cnt      = w_cnt_inc;
                        w_mem_addr = {r_blk, w_cnt_inc};
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy        = r_busy;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.line_wr     = r_line_wr;
    assign bus.refill_done = r_line_wr;
    assign bus.line_addr   = r_line_addr;
    assign bus.line_data   = r_line_data;
endmodule
